// File: rtl/bar_addr_decoder.sv
// bar_addr_decoder: snapshots six BARs and decodes request addresses into BAR index and offset over a 2-stage valid/ready pipe.
// Optional BAR_DECODE_MISS_COUNT_EN adds a saturating, clearable 16-bit miss counter.
module bar_addr_decoder #(
  parameter int BAR0_SIZE_BITS = 12,
  parameter int BAR1_SIZE_BITS = 12,
  parameter int BAR2_SIZE_BITS = 12,
  parameter int BAR3_SIZE_BITS = 12,
  parameter int BAR4_SIZE_BITS = 12,
  parameter int BAR5_SIZE_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cfg_finished,
  input  logic [31:0] i_bar_addr0,
  input  logic [31:0] i_bar_addr1,
  input  logic [31:0] i_bar_addr2,
  input  logic [31:0] i_bar_addr3,
  input  logic [31:0] i_bar_addr4,
  input  logic [31:0] i_bar_addr5,
  output logic        o_bars_loaded,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_is_io,
  output logic        o_hit_valid,
  input  logic        i_hit_ready,
  output logic [2:0]  o_hit_bar,
  output logic        o_hit_miss,
  output logic [31:0] o_hit_offset
`ifdef BAR_DECODE_MISS_COUNT_EN
  ,
  input  logic        i_miss_count_clear,
  output logic [15:0] o_miss_count
`endif
);
  localparam int SZ [6] = '{BAR0_SIZE_BITS, BAR1_SIZE_BITS, BAR2_SIZE_BITS,
                            BAR3_SIZE_BITS, BAR4_SIZE_BITS, BAR5_SIZE_BITS};
  logic [31:0] bar_in [6];
  logic [31:0] snap [6];
  logic [31:0] off [6];
  logic [5:0]  hit;
  logic        fin_q;
  logic        s1_valid;
  logic        s1_io;
  logic [31:0] s1_addr;
  logic        advance;
  logic [2:0]  d_bar;
  logic        d_miss;
  logic [31:0] d_off;
  assign bar_in[0] = i_bar_addr0;
  assign bar_in[1] = i_bar_addr1;
  assign bar_in[2] = i_bar_addr2;
  assign bar_in[3] = i_bar_addr3;
  assign bar_in[4] = i_bar_addr4;
  assign bar_in[5] = i_bar_addr5;
  assign advance = !o_hit_valid || i_hit_ready;
  assign o_req_ready = !s1_valid || advance;
  // Snapshot only on a rising edge of the finished level, so a held level never reloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fin_q <= 1'b0;
      o_bars_loaded <= 1'b0;
      for (int i = 0; i < 6; i++) snap[i] <= '0;
    end else begin
      fin_q <= i_cfg_finished;
      if (i_cfg_finished && !fin_q) begin
        o_bars_loaded <= 1'b1;
        for (int i = 0; i < 6; i++) snap[i] <= bar_in[i];
      end
    end
  end
  for (genvar g = 0; g < 6; g++) begin : g_bar
    localparam logic [31:0] HI = 32'hFFFF_FFFF << SZ[g];
    logic [31:0] base;
    assign base = {snap[g][31:4], 4'h0};
    assign hit[g] = (base != '0) && (snap[g][0] == s1_io) && (((s1_addr ^ base) & HI) == '0);
    assign off[g] = s1_addr & ~HI;
  end
  // Scan high to low so the lowest-index hit overrides.
  always_comb begin
    d_bar = 3'd7;
    d_off = s1_addr;
    for (int i = 5; i >= 0; i--) begin
      if (o_bars_loaded && hit[i]) begin
        d_bar = 3'(i);
        d_off = off[i];
      end
    end
    d_miss = d_bar == 3'd7;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_addr <= '0;
      s1_io <= 1'b0;
    end else if (o_req_ready) begin
      s1_valid <= i_req_valid;
      if (i_req_valid) begin
        s1_addr <= i_req_addr;
        s1_io <= i_req_is_io;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_hit_valid <= 1'b0;
      o_hit_bar <= 3'd7;
      o_hit_miss <= 1'b1;
      o_hit_offset <= '0;
    end else if (advance) begin
      o_hit_valid <= s1_valid;
      if (s1_valid) begin
        o_hit_bar <= d_bar;
        o_hit_miss <= d_miss;
        o_hit_offset <= d_off;
      end
    end
  end
`ifdef BAR_DECODE_MISS_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_miss_count <= '0;
    else if (i_miss_count_clear) o_miss_count <= '0;
    else if (advance && s1_valid && d_miss && o_miss_count != 16'hFFFF) o_miss_count <= o_miss_count + 16'd1;
  end
`endif
endmodule
